// File: rtl/xor_ctrl_pkg.sv
// Shared definitions for the XOR checksum controller: FSM state encoding
// and default datapath widths.
package xor_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_LEN_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_e;

endpackage

// File: rtl/xor_gate.sv
// Single-bit XOR cell used to build the checksum fold.
module xor_gate (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

// File: rtl/xor_vec.sv
// WIDTH-bit carry-free XOR of two words, one xor_gate per bit.
module xor_vec #(
    parameter int WIDTH = xor_ctrl_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        xor_gate u_gate (
            .a (a[i]),
            .b (b[i]),
            .y (y[i])
        );
    end

endmodule

// File: rtl/xor_accum_ctrl.sv
// Burst XOR checksum controller: accepts len words via valid/ready, folds
// them into an accumulator and presents the result until the consumer takes it.
//
// state  | meaning
// IDLE   | waiting for start; len captured on accept
// ACCUM  | in_ready high, folding words, remaining counts down to 0
// RESULT | out_valid high, out_data held until out_ready
module xor_accum_ctrl
    import xor_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LEN_W = DEFAULT_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    state_e           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [LEN_W-1:0] remaining;

    xor_vec #(.WIDTH(WIDTH)) u_fold (
        .a (acc),
        .b (in_data),
        .y (acc_next)
    );

    assign out_data = acc;

    // in_ready mirrors state==ACCUM, so in_valid alone qualifies a transfer there.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= '0;
                        busy <= 1'b1;
                        if (len != '0) begin
                            remaining <= len;
                            in_ready  <= 1'b1;
                            state     <= ACCUM;
                        end else begin
                            remaining <= '0;
                            out_valid <= 1'b1;
                            state     <= RESULT;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc       <= acc_next;
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= RESULT;
                        end
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b0;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_accum_ctrl.sv
// Scoreboard bench for xor_accum_ctrl: jobs push their expected checksum,
// a monitor pops and compares on every out_valid/out_ready handshake.
module tb_xor_accum_ctrl;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             busy;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] words[16];

    always #5 clk = ~clk;

    xor_accum_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(out_data), 32'hDEAD);
            end else begin
                check("scoreboard_out_data", 32'(out_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n words from words[], gap idle cycles between words, bp cycles of
    // out_ready low, optional stray start mid-burst and on the ack cycle.
    task automatic run_job(input int n, input int gap, input int bp,
                           input bit stray_start, input bit start_on_ack);
        logic [WIDTH-1:0] exp;
        exp = '0;
        for (int i = 0; i < n; i++) exp ^= words[i];
        sb.push_back(exp);

        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
        len   = LEN_W'($urandom_range(0, 15));

        if (n == 0) begin
            @(negedge clk);
            check("zero_len_out_valid", 32'(out_valid), 32'd1);
            check("zero_len_in_ready", 32'(in_ready), 32'd0);
            check("zero_len_out_data", 32'(out_data), 32'd0);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (i > 0) begin
                    for (int g = 0; g < gap; g++) begin
                        in_valid = 1'b0;
                        in_data  = WIDTH'($urandom);
                        if (stray_start && i == 1 && g == 0) begin
                            start = 1'b1;
                            len   = LEN_W'(5);
                        end
                        @(negedge clk);
                        check("gap_in_ready", 32'(in_ready), 32'd1);
                        check("gap_out_valid", 32'(out_valid), 32'd0);
                        tick();
                        start = 1'b0;
                    end
                end
                in_valid = 1'b1;
                in_data  = words[i];
                @(negedge clk);
                check("accum_in_ready", 32'(in_ready), 32'd1);
                check("accum_busy", 32'(busy), 32'd1);
                check("accum_out_valid", 32'(out_valid), 32'd0);
                tick();
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("latency_out_valid", 32'(out_valid), 32'd1);
            check("result_in_ready", 32'(in_ready), 32'd0);
        end

        for (int b = 0; b < bp; b++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data", 32'(out_data), 32'(exp));
            tick();
        end
        out_ready = 1'b1;
        if (start_on_ack) begin
            start = 1'b1;
            len   = LEN_W'(3);
        end
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        check("ack_busy", 32'(busy), 32'd0);
        check("ack_out_valid", 32'(out_valid), 32'd0);
        check("ack_in_ready", 32'(in_ready), 32'd0);
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        tick();

        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
        run_job(3, 0, 0, 1'b0, 1'b0);

        words[0] = 8'h0F; words[1] = 8'hF0;
        run_job(2, 3, 0, 1'b0, 1'b0);

        words[0] = 8'h12; words[1] = 8'h34; words[2] = 8'h56;
        run_job(3, 0, 5, 1'b0, 1'b0);

        run_job(0, 0, 2, 1'b0, 1'b0);

        words[0] = 8'h81; words[1] = 8'h42; words[2] = 8'h24;
        run_job(3, 2, 1, 1'b1, 1'b1);

        // reset mid-ACCUM with len=3 after one word
        start = 1'b1; len = LEN_W'(3);
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h77;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        check("midjob_reset_busy", 32'(busy), 32'd0);
        check("midjob_reset_out_valid", 32'(out_valid), 32'd0);
        check("midjob_reset_out_data", 32'(out_data), 32'd0);
        check("midjob_reset_in_ready", 32'(in_ready), 32'd0);
        tick();

        words[0] = 8'hC3; words[1] = 8'h3C;
        run_job(2, 0, 0, 1'b0, 1'b0);

        for (int j = 0; j < 40; j++) begin
            int n;
            n = $urandom_range(0, 15);
            for (int k = 0; k < 16; k++) words[k] = WIDTH'($urandom);
            run_job(n, $urandom_range(0, 2), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/xor_accum_ctrl.md
XOR_ACCUM_CTRL -- requirements
Module: xor_accum_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data word width in bits.
REQ-002 Parameter LEN_W, default 4, SHALL set the length field width (max burst 2^LEN_W-1 words).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 Port start  input  1  SHALL request a new checksum job; sampled only in IDLE.
REQ-006 Port len  input  LEN_W  SHALL give the job word count; captured when start is accepted.
REQ-007 Port in_valid  input  1  SHALL mark in_data valid.
REQ-008 Port in_data  input  WIDTH  SHALL carry the word to fold into the accumulator.
REQ-009 Port in_ready  output  1  SHALL indicate the block accepts a word this cycle.
REQ-010 Port busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-011 Port out_valid  output  1  SHALL mark out_data as a completed checksum.
REQ-012 Port out_data  output  WIDTH  SHALL carry the XOR of all accepted words of the job.
REQ-013 Port out_ready  input  1  SHALL indicate the consumer takes out_data this cycle.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCUM, RESULT.
REQ-015 In IDLE, start=1 with len!=0 SHALL capture len into a remaining-count register, clear the accumulator to 0, and enter ACCUM next cycle.
REQ-016 In IDLE, start=1 with len==0 SHALL clear the accumulator and enter RESULT directly (out_data=0).
REQ-017 in_ready SHALL be 1 only in ACCUM; a word transfers on a cycle with in_valid=1 and in_ready=1.
REQ-018 On each transfer the accumulator SHALL become accumulator XOR in_data and the remaining count SHALL decrement by 1.
REQ-019 A transfer with remaining count 1 SHALL be the last; the FSM SHALL enter RESULT the next cycle with the final value.
REQ-020 In ACCUM with in_valid=0 the state, accumulator and count SHALL hold (no timeout).
REQ-021 out_valid SHALL be 1 only in RESULT; out_data SHALL equal the accumulator, stable while out_valid=1 and out_ready=0.
REQ-022 In RESULT, out_ready=1 SHALL return the FSM to IDLE next cycle; a start in that same cycle SHALL be ignored.
REQ-023 start asserted outside IDLE SHALL be ignored, with no effect on len capture or the accumulator.
REQ-024 Latency SHALL be: first word accepted the cycle after start; out_valid the cycle after the last transfer.
REQ-025 Arithmetic SHALL be bitwise XOR over WIDTH bits; there SHALL be no carry and no width growth.

Reset
REQ-026 rst=1 SHALL force, on the next edge: state=IDLE, accumulator=0, remaining count=0.
REQ-027 Reset outputs SHALL be: in_ready=0, busy=0, out_valid=0, out_data=0.
REQ-028 rst SHALL have priority over all other inputs, including mid-job in ACCUM or RESULT; the partial job SHALL be discarded.

Structure
REQ-029 The state enumeration (IDLE, ACCUM, RESULT) and the default WIDTH/LEN_W constants SHALL live in the shared package xor_ctrl_pkg.
REQ-030 The combinational fold SHALL be one sub-module, xor_vec: a WIDTH-bit XOR of two words built from per-bit xor_gate instances.
REQ-031 All outputs SHALL be derived from registered state with no combinational path from start/len to outputs.

Verification
REQ-032 The bench SHALL check reset: hold rst 2 cycles mid-ACCUM (len=3, one word sent) -> IDLE, busy=0, out_valid=0, out_data=0.
REQ-033 The bench SHALL check a basic job: WIDTH=8, len=3, words 0xA5, 0x3C, 0xFF streamed back-to-back -> out_valid the cycle after the third transfer, out_data=0x66.
REQ-034 The bench SHALL check input gaps: len=2, words 0x0F and 0xF0 with in_valid low 3 cycles between -> out_data=0xFF, in_ready high throughout ACCUM.
REQ-035 The bench SHALL check output backpressure: out_ready low 5 cycles in RESULT -> out_valid and out_data stable; completes on the first out_ready=1 cycle.
REQ-036 The bench SHALL check zero length: start with len=0 -> RESULT next cycle, out_data=0x00, no in_ready pulse.
REQ-037 The bench SHALL check ignored start: start pulsed during ACCUM with len=5 -> no change to the remaining count; the job completes after the original len words.
